sram_stream_ctrl: RTL

// Upstream driver for the single-port sram: turns valid/ready word streams into SRAM bursts.
// A write burst stores i_len words from the input stream at consecutive addresses from i_base.
// A read burst streams i_len words back out with full backpressure support.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/sram_stream_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM stream controller: FSM encoding and SRAM pin levels.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic CE_ON  = 1'b0;
  localparam logic CE_OFF = 1'b1;
  localparam logic RD     = 1'b1;
  localparam logic WR     = 1'b0;

  // Read skid buffer depth; also the ceiling on outstanding read credits.
  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count, used as the read-return skid buffer.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Out-of-range requests are dropped so occupancy can never go wrong.
  assign w_push = i_push & ~w_full;
  assign w_pop  = i_pop & ~o_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_N) begin
    if (!i_rst_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_ctrl.sv
// Stream-to-SRAM burst controller: valid/ready write bursts into, and read bursts out of,
// a single-port SRAM with registered pins and a 2-cycle read latency.
module sram_stream_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_N,
  input  logic                  i_start_wr,
  input  logic                  i_start_rd,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic                  i_s_valid,
  input  logic [WIDTH-1:0]      i_s_data,
  output logic                  o_s_ready,
  output logic                  o_m_valid,
  output logic [WIDTH-1:0]      o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ce_N,
  output logic                  o_rdWr_N,
  output logic [ADDR_WIDTH-1:0] o_ramAddr,
  output logic [WIDTH-1:0]      o_ramData,
  input  logic [WIDTH-1:0]      i_ramData
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [ADDR_WIDTH:0]   r_out_remain;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic                  r_done;
  logic                  r_ce_N;
  logic                  r_rdWr_N;
  logic [ADDR_WIDTH-1:0] r_ramAddr;
  logic [WIDTH-1:0]      r_ramData;

  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic                  w_s_beat;
  logic                  w_m_hs;
  logic                  w_issue;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W-1:0]      w_credit_used;
  logic                  w_fifo_empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rd_fifo (
    .i_clk   (i_clk),
    .i_rst_N (i_rst_N),
    .i_push  (r_rd_p2),
    .i_data  (i_ramData),
    .i_pop   (w_m_hs),
    .o_data  (o_m_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_ptr_next = (r_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;

  assign o_s_ready = (r_state == WRITE) && (r_remain != '0);
  assign o_m_valid = ~w_fifo_empty;
  assign o_m_last  = o_m_valid && (r_out_remain == LEN_ONE);
  assign o_busy    = (r_state != IDLE);
  assign o_done    = r_done;
  assign o_ce_N    = r_ce_N;
  assign o_rdWr_N  = r_rdWr_N;
  assign o_ramAddr = r_ramAddr;
  assign o_ramData = r_ramData;

  assign w_s_beat = i_s_valid & o_s_ready;
  assign w_m_hs   = o_m_valid & i_m_ready;

  // Reads still in the SRAM pipeline plus words already buffered must leave
  // room in the FIFO for everything that will land, even with no pops.
  assign w_credit_used = CNT_W'(r_rd_p1) + CNT_W'(r_rd_p2) + w_fifo_count;
  assign w_issue = (r_state == READ) && (r_remain != '0) &&
                   (w_credit_used < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_N) begin
    if (!i_rst_N) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_remain     <= '0;
      r_out_remain <= '0;
      r_rd_p1      <= 1'b0;
      r_rd_p2      <= 1'b0;
      r_done       <= 1'b0;
      r_ce_N       <= CE_OFF;
      r_rdWr_N     <= RD;
      r_ramAddr    <= '0;
      r_ramData    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_ce_N   <= CE_OFF;
      r_rdWr_N <= RD;
      r_rd_p1  <= w_issue;
      r_rd_p2  <= r_rd_p1;

      case (r_state)
        IDLE: begin
          if (i_start_wr || i_start_rd) begin
            r_ptr        <= i_base;
            r_remain     <= i_len;
            r_out_remain <= i_len;
            if (i_len == '0) begin
              r_done <= 1'b1;
            end else if (i_start_wr) begin
              r_state <= WRITE;
            end else begin
              r_state <= READ;
            end
          end
        end

        WRITE: begin
          if (w_s_beat) begin
            r_ce_N    <= CE_ON;
            r_rdWr_N  <= WR;
            r_ramAddr <= r_ptr;
            r_ramData <= i_s_data;
            r_ptr     <= w_ptr_next;
            r_remain  <= r_remain - 1'b1;
            if (r_remain == LEN_ONE) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end

        READ: begin
          if (w_issue) begin
            r_ce_N    <= CE_ON;
            r_rdWr_N  <= RD;
            r_ramAddr <= r_ptr;
            r_ptr     <= w_ptr_next;
            r_remain  <= r_remain - 1'b1;
          end
          if (w_m_hs) begin
            r_out_remain <= r_out_remain - 1'b1;
            if (r_out_remain == LEN_ONE) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
